// File: rtl/digit_scan_ctrl_if.sv
// Bus bundle for digit_scan_ctrl.
// The master (host/testbench) drives the scan enable, the load strobe and the
// display word. The slave (digit_scan_ctrl) returns the decoder select/enable,
// the current digit nibble and the pending flag.
//   en       scan enable; 0 = idle/blank
//   load     one-cycle strobe to capture data_in
//   data_in  four nibbles, [15:12] = position 3 ... [3:0] = position 0
//   sel      position select to decoder A[1:0]
//   sel_en   decoder enable E
//   digit    nibble of the display word at position sel
//   pending  new word captured but not yet committed
interface digit_scan_ctrl_if;
    logic        en;
    logic        load;
    logic [15:0] data_in;
    logic [1:0]  sel;
    logic        sel_en;
    logic [3:0]  digit;
    logic        pending;

    modport master (
        output en, load, data_in,
        input  sel, sel_en, digit, pending
    );

    modport slave (
        input  en, load, data_in,
        output sel, sel_en, digit, pending
    );
endinterface

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-position one-hot select stage.
// Each position is shown for DIV cycles, followed by one dead-time cycle with
// the decoder disabled. The 16-bit display word is double buffered: loads
// land in a shadow register and are committed only at a frame boundary (the
// dead-time cycle of position 3, or any idle cycle) so a frame never tears.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous, active-high reset
//   bus  digit_scan_ctrl_if.slave (en, load, data_in -> sel, sel_en, digit, pending)
// Parameters:
//   DIV  dwell per position in clk cycles, >= 1
// Optional build macro LEAD_BLANK_EN: blank leading-zero positions 3..1.
module digit_scan_ctrl #(
    parameter int unsigned DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    digit_scan_ctrl_if.slave  bus
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {StIdle, StShow, StGap} state_e;

    state_e      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] display_q, display_d;
    logic        pending_q, pending_d;
    logic        sel_en_q, sel_en_d;
    logic [3:0]  digit_q, digit_d;
    logic        boundary;
    logic        blank;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            sel_q     <= 2'd0;
            presc_q   <= '0;
            shadow_q  <= 16'h0000;
            display_q <= 16'h0000;
            pending_q <= 1'b0;
            sel_en_q  <= 1'b0;
            digit_q   <= 4'h0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            presc_q   <= presc_d;
            shadow_q  <= shadow_d;
            display_q <= display_d;
            pending_q <= pending_d;
            sel_en_q  <= sel_en_d;
            digit_q   <= digit_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        presc_d   = presc_q;
        shadow_d  = shadow_q;
        display_d = display_q;
        pending_d = pending_q;
        blank     = 1'b0;

        // Double buffer: a load coincident with a boundary bypasses the shadow.
        boundary = (state_q == StIdle) || ((state_q == StGap) && (sel_q == 2'd3));
        if (boundary) begin
            if (bus.load) begin
                display_d = bus.data_in;
            end else if (pending_q) begin
                display_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (bus.load) begin
            shadow_d  = bus.data_in;
            pending_d = 1'b1;
        end

        if (!bus.en) begin
            state_d = StIdle;
            sel_d   = 2'd0;
            presc_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StShow;
                    sel_d   = 2'd0;
                    presc_d = '0;
                end
                StShow: begin
                    if (presc_q == PW'(DIV - 1)) begin
                        state_d = StGap;
                        presc_d = '0;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                StGap: begin
                    state_d = StShow;
                    sel_d   = sel_q + 2'd1;
                    presc_d = '0;
                end
                default: begin
                    state_d = StIdle;
                    sel_d   = 2'd0;
                    presc_d = '0;
                end
            endcase
        end

`ifdef LEAD_BLANK_EN
        // Blank position p when nibbles p..3 of the word being shown are all zero.
        case (sel_d)
            2'd3:    blank = (display_d[15:12] == 4'h0);
            2'd2:    blank = (display_d[15:8] == 8'h00);
            2'd1:    blank = (display_d[15:4] == 12'h000);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif

        // Outputs are registered from next-state values so digit tracks sel.
        sel_en_d = (state_d == StShow) && !blank;
        digit_d  = display_d[{sel_d, 2'b00} +: 4];
    end

    assign bus.sel     = sel_q;
    assign bus.sel_en  = sel_en_q;
    assign bus.digit   = digit_q;
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl. A stimulus process drives inputs on
// the falling edge and pushes the expected post-edge outputs, computed by a
// frame-time model, into a queue; a monitor pops and compares after each
// rising edge.
module tb_digit_scan_ctrl;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * (DIV + 1);

    typedef struct packed {
        logic [1:0] sel;
        logic       sel_en;
        logic [3:0] digit;
        logic       pending;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    digit_scan_ctrl_if bus ();

    digit_scan_ctrl #(.DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    // Model: running flag plus time-into-frame; positions and dwell follow
    // directly from t / (DIV+1) and t % (DIV+1).
    bit          m_run    = 1'b0;
    int          m_t      = 0;
    logic [15:0] m_disp   = 16'h0;
    logic [15:0] m_shadow = 16'h0;
    logic        m_pend   = 1'b0;

    function automatic int cur_pos();
        return m_run ? (m_t / (DIV + 1)) : 0;
    endfunction

    function automatic int cur_phase();
        return m_t % (DIV + 1);
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic l, input logic [15:0] d);
        exp_t x;
        bit   bnd;
        int   pos;
        bit   blank;
        @(negedge clk);
        rst         = r;
        bus.en      = e;
        bus.load    = l;
        bus.data_in = d;
        if (r) begin
            m_run    = 1'b0;
            m_t      = 0;
            m_disp   = 16'h0;
            m_shadow = 16'h0;
            m_pend   = 1'b0;
        end else begin
            bnd = !m_run || (m_t == FRAME - 1);
            if (bnd) begin
                if (l) m_disp = d;
                else if (m_pend) m_disp = m_shadow;
                m_pend = 1'b0;
            end else if (l) begin
                m_shadow = d;
                m_pend   = 1'b1;
            end
            if (!e) begin
                m_run = 1'b0;
                m_t   = 0;
            end else if (!m_run) begin
                m_run = 1'b1;
                m_t   = 0;
            end else begin
                m_t = (m_t + 1) % FRAME;
            end
        end
        pos   = cur_pos();
        blank = 1'b0;
`ifdef LEAD_BLANK_EN
        blank = (pos > 0) && ((m_disp >> (4 * pos)) == 16'h0);
`endif
        x.sel     = pos[1:0];
        x.sel_en  = m_run && (cur_phase() < DIV) && !blank;
        x.digit   = 4'((m_disp >> (4 * pos)) & 16'hF);
        x.pending = m_pend;
        exp_q.push_back(x);
    endtask

    // Monitor: compare once per rising edge, away from the edge itself.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sel",     int'(bus.sel),     int'(e.sel));
                check("sel_en",  int'(bus.sel_en),  int'(e.sel_en));
                check("digit",   int'(bus.digit),   int'(e.digit));
                check("pending", int'(bus.pending), int'(e.pending));
            end
        end
    end

    initial begin
        logic        r, e, l;
        logic [15:0] d;
        bus.en      = 1'b1;
        bus.load    = 1'b1;
        bus.data_in = 16'hFFFF;

        // Reset held with en and load asserted.
        step(1'b1, 1'b1, 1'b1, 16'hFFFF);
        step(1'b1, 1'b1, 1'b1, 16'hFFFF);

        // Load in idle commits directly, then scan past one frame wrap.
        step(1'b0, 1'b0, 1'b1, 16'h1234);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (FRAME + 2) step(1'b0, 1'b1, 1'b0, 16'h0000);

        // Mid-frame update while position 1 is shown.
        for (int i = 0; i < 4 * FRAME && !(cur_pos() == 1 && cur_phase() == 0); i++)
            step(1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b1, 16'hABCD);
        repeat (FRAME) step(1'b0, 1'b1, 1'b0, 16'h0000);

        // Disable at position 2, then re-enable with a full dwell.
        for (int i = 0; i < 4 * FRAME && !(cur_pos() == 2 && cur_phase() == 1); i++)
            step(1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (DIV + 3) step(1'b0, 1'b1, 1'b0, 16'h0000);

        // Pending shadow superseded by a load on the frame-boundary cycle.
        for (int i = 0; i < 4 * FRAME && cur_pos() != 1; i++)
            step(1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b1, 16'h1111);
        for (int i = 0; i < 4 * FRAME && !(m_run && m_t == FRAME - 1); i++)
            step(1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b1, 16'h5678);
        repeat (FRAME) step(1'b0, 1'b1, 1'b0, 16'h0000);

        // Leading-zero word.
        step(1'b0, 1'b0, 1'b1, 16'h0050);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (FRAME + 2) step(1'b0, 1'b1, 1'b0, 16'h0000);

        // Reset mid-frame.
        repeat (7) step(1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b1, 1'b1, 1'b1, 16'h9999);
        repeat (3) step(1'b0, 1'b1, 1'b0, 16'h0000);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(99) < 2);
            e = ($urandom_range(99) < 92);
            l = ($urandom_range(99) < 10);
            d = 16'($urandom);
            if ($urandom_range(3) == 0) d = d & 16'h00FF;
            if ($urandom_range(7) == 0) d = d & 16'h000F;
            step(r, e, l, d);
        end

        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
- Time-multiplexed scan controller for a 4-position one-hot select stage.
- Drives the 2-bit select and enable inputs of the downstream 2-to-4 decoder.
- Presents the 4-bit digit value for the currently selected position.
- Holds a double-buffered 16-bit display word so updates never tear mid-frame.

Parameters:
DIV, 4, SHOW-state dwell per position in clk cycles; legal range >=1.

Ports:
clk      input   1   system clock, all logic on rising edge
rst      input   1   synchronous, active-high reset
en       input   1   scan enable; 0 = idle/blank
load     input   1   one-cycle strobe; capture data_in
data_in  input   16  four nibbles; [15:12] = position 3 (most significant) ... [3:0] = position 0
sel      output  2   position select to decoder A[1:0]
sel_en   output  1   decoder enable E
digit    output  4   nibble of display word at position sel
pending  output  1   new word captured but not yet committed

Behaviour:
- Reset: state=IDLE, sel=0, sel_en=0, digit=0, pending=0, prescaler=0; shadow and display registers = 0.
- All outputs are registered. digit always equals display[4*sel+3:4*sel] in the same cycle as sel.
- FSM states: IDLE, SHOW, GAP.
- IDLE:
  - sel=0, sel_en=0, prescaler=0.
  - en=1 -> SHOW next cycle with sel=0, sel_en=1.
- SHOW:
  - sel_en=1; prescaler counts 0..DIV-1.
  - At count DIV-1 -> GAP next cycle.
- GAP:
  - Exactly 1 cycle; sel_en=0 (anti-ghosting dead time); sel unchanged.
  - Next cycle -> SHOW with sel=(sel+1) mod 4; wrap 3->0; prescaler=0.
- Frame period = 4*(DIV+1) cycles.
- en=0 in any state -> IDLE next cycle: sel=0, sel_en=0, prescaler=0. Re-enable always restarts at position 0.
- Frame boundary = GAP cycle with sel==3. In IDLE, every cycle counts as a boundary.
- load:
  - load=1, not at a boundary: shadow<=data_in, pending<=1. A later load overwrites the shadow (latest wins).
  - At a boundary with pending=1: display<=shadow, pending<=0.
  - load=1 coincident with a boundary: display<=data_in directly, pending<=0. The older shadow is discarded.
- rst overrides en and load in the same cycle. Reset mid-frame returns everything to the reset values above next cycle.
- The prescaler is wide enough for DIV-1. No overflow is possible.

Optional Feature:
Macro LEAD_BLANK_EN.
- Defined:
  - During SHOW, sel_en is forced to 0 at position p (p = 3, 2, 1) when nibbles p..3 of the display word are all zero.
  - Position 0 is never blanked.
  - digit still outputs the nibble.
- Not defined: sel_en=1 for every SHOW cycle regardless of value.

Test Plan:
1. rst=1 for 2 cycles with en=1, load=1 -> sel=0, sel_en=0, digit=0, pending=0 while reset is held; SHOW entered only after rst falls.
2. DIV=4, load 0x1234 in IDLE, then en=1:
   - display=0x1234, pending stays 0.
   - Sequence: sel=0/digit=4 for 4 cycles, 1-cycle sel_en=0, then sel=1/digit=3, sel=2/digit=2, sel=3/digit=1.
   - sel wraps to 0 after 20 cycles.
3. Mid-frame update, while sel=1:
   - load 0xABCD -> pending=1; digit still 3, then 2, then 1.
   - After the sel=3 GAP cycle: sel=0, digit=D, pending=0.
4. en=0 during SHOW at sel=2 -> next cycle sel=0, sel_en=0. en=1 again -> one cycle later sel=0, sel_en=1, full DIV dwell.
5. pending=1 (shadow 0x1111), load 0x5678 on the sel=3 GAP cycle -> next cycle sel=0, digit=8, pending=0; 0x1111 never displayed.
6. With LEAD_BLANK_EN, display 0x0050 -> sel_en=0 for sel=3 and sel=2; sel_en=1 for sel=1 (digit=5) and sel=0 (digit=0). Without the macro, sel_en=1 for all four positions.
